// File: rtl/bullet_sched_pkg.sv
// Shared types and constants for the bullet scheduler: slot states,
// position/direction widths and the direction encoding.
package bullet_sched_pkg;

  localparam int POS_W = 5;
  localparam int DIR_W = 2;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'b00;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'b01;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'b10;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    FLY,
    RELEASE
  } slot_state_t;

endpackage

// File: rtl/bullet_slot_fsm.sv
// One bullet engine slot: feedback synchronizer, launch/fly sequencer,
// launch timeout and the shot parameters captured at grant time.
module bullet_slot_fsm
  import bullet_sched_pkg::*;
#(
  parameter int OW        = 2,
  parameter int LAUNCH_TO = 8_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grant,
  input  logic [POS_W-1:0] x_in,
  input  logic [POS_W-1:0] y_in,
  input  logic [DIR_W-1:0] dir_in,
  input  logic [OW-1:0]    owner_in,
  input  logic             fb,
  output logic             bul_state,
  output logic [DIR_W-1:0] bul_dir,
  output logic [POS_W-1:0] bul_x_init,
  output logic [POS_W-1:0] bul_y_init,
  output logic [OW-1:0]    owner,
  output logic             idle,
  output logic             releasing,
  output logic             busy_nx
);

  localparam logic [23:0] TO_LAST = 24'(LAUNCH_TO - 1);

  slot_state_t state, next_state;
  logic        fb_q1, fb_s;
  logic [23:0] to_cnt;
  logic        bul_state_d;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant) next_state = LOAD;
      LOAD:    next_state = LAUNCH;
      LAUNCH: begin
        if (fb_s)                  next_state = FLY;
        else if (to_cnt == TO_LAST) next_state = RELEASE;
      end
      FLY:     if (!fb_s) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The launch level is registered from the next state so it is glitch-free
  // and drops on the same edge that sampled a reset.
  always_comb begin
    bul_state_d = (next_state == LAUNCH) || (next_state == FLY);
    busy_nx     = (next_state != IDLE);
    idle        = (state == IDLE);
    releasing   = (state == RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_q1      <= 1'b0;
      fb_s       <= 1'b0;
      to_cnt     <= '0;
      bul_state  <= 1'b0;
      bul_dir    <= DIR_UP;
      bul_x_init <= '0;
      bul_y_init <= '0;
      owner      <= '0;
    end else begin
      fb_q1     <= fb;
      fb_s      <= fb_q1;
      to_cnt    <= (state == LAUNCH) ? to_cnt + 24'd1 : '0;
      bul_state <= bul_state_d;
      if (state == IDLE && grant) begin
        bul_dir    <= dir_in;
        bul_x_init <= x_in;
        bul_y_init <= y_in;
        owner      <= owner_in;
      end
    end
  end

endmodule

// File: rtl/bullet_scheduler.sv
// Round-robin fire arbiter sharing N_BUL bullet engines among N_TANK tanks.
// Optional per-tank re-arm delay enabled by defining BULLET_COOLDOWN_EN.
module bullet_scheduler
  import bullet_sched_pkg::*;
#(
  parameter int N_TANK    = 4,
  parameter int N_BUL     = 4,
  parameter int LAUNCH_TO = 8_000_000,
  parameter int COOLDOWN  = 6_250_000,
  localparam int OW       = $clog2(N_TANK)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_TANK-1:0]       fire_req,
  input  logic [N_TANK*POS_W-1:0] fire_x,
  input  logic [N_TANK*POS_W-1:0] fire_y,
  input  logic [N_TANK*DIR_W-1:0] fire_dir,
  output logic [N_TANK-1:0]       fire_ack,
  output logic [N_TANK-1:0]       fire_busy,
  output logic [N_BUL-1:0]        bul_state,
  output logic [N_BUL*DIR_W-1:0]  bul_dir,
  output logic [N_BUL*POS_W-1:0]  bul_x_init,
  output logic [N_BUL*POS_W-1:0]  bul_y_init,
  input  logic [N_BUL-1:0]        bul_fb,
  output logic [N_BUL*OW-1:0]     slot_owner
);

  localparam int SW = (N_BUL > 1) ? $clog2(N_BUL) : 1;

  logic [N_TANK-1:0] eligible, cd_ok, busy_d;
  logic [N_BUL-1:0]  slot_idle, slot_rel, slot_busy_nx, slot_grant;
  logic [OW-1:0]     rr_ptr, winner, idx;
  logic [OW:0]       sum;
  logic [SW-1:0]     free_slot;
  logic              found, any_idle, grant_valid;
  logic [POS_W-1:0]  grant_x, grant_y;
  logic [DIR_W-1:0]  grant_dir;

  // Search tanks cyclically from rr_ptr; pick the lowest-index idle slot.
  always_comb begin
    eligible  = fire_req & ~fire_busy & cd_ok;
    found     = 1'b0;
    winner    = rr_ptr;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < N_TANK; k++) begin
      sum = {1'b0, rr_ptr} + (OW+1)'(k);
      if (sum >= (OW+1)'(N_TANK)) sum = sum - (OW+1)'(N_TANK);
      idx = sum[OW-1:0];
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    any_idle  = 1'b0;
    free_slot = '0;
    for (int s = N_BUL - 1; s >= 0; s--) begin
      if (slot_idle[s]) begin
        any_idle  = 1'b1;
        free_slot = SW'(s);
      end
    end
    grant_valid = found && any_idle;
    slot_grant  = '0;
    if (grant_valid) slot_grant[free_slot] = 1'b1;
    grant_x   = '0;
    grant_y   = '0;
    grant_dir = '0;
    for (int t = 0; t < N_TANK; t++) begin
      if (winner == OW'(t)) begin
        grant_x   = fire_x[t*POS_W +: POS_W];
        grant_y   = fire_y[t*POS_W +: POS_W];
        grant_dir = fire_dir[t*DIR_W +: DIR_W];
      end
    end
  end

  // A tank is busy next cycle if any slot it will own is not heading to IDLE.
  always_comb begin
    busy_d = '0;
    for (int s = 0; s < N_BUL; s++) begin
      for (int t = 0; t < N_TANK; t++) begin
        if (slot_busy_nx[s] &&
            ((slot_grant[s] ? winner : slot_owner[s*OW +: OW]) == OW'(t)))
          busy_d[t] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      fire_ack  <= '0;
      fire_busy <= '0;
    end else begin
      fire_ack  <= '0;
      fire_busy <= busy_d;
      if (grant_valid) begin
        fire_ack[winner] <= 1'b1;
        rr_ptr <= (winner == OW'(N_TANK - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

`ifdef BULLET_COOLDOWN_EN
  localparam int CD_W = $clog2(COOLDOWN + 1);
  logic [CD_W-1:0]   cd_cnt [N_TANK];
  logic [N_TANK-1:0] cd_load;

  always_comb begin
    cd_load = '0;
    for (int s = 0; s < N_BUL; s++)
      if (slot_rel[s]) cd_load[slot_owner[s*OW +: OW]] = 1'b1;
    for (int t = 0; t < N_TANK; t++)
      cd_ok[t] = (cd_cnt[t] == '0);
  end

  always_ff @(posedge clk) begin
    for (int t = 0; t < N_TANK; t++) begin
      if (rst)                 cd_cnt[t] <= '0;
      else if (cd_load[t])     cd_cnt[t] <= CD_W'(COOLDOWN);
      else if (cd_cnt[t] != 0) cd_cnt[t] <= cd_cnt[t] - 1'b1;
    end
  end
`else
  assign cd_ok = {N_TANK{COOLDOWN >= 0}};
`endif

  for (genvar s = 0; s < N_BUL; s++) begin : g_slot
    bullet_slot_fsm #(
      .OW        (OW),
      .LAUNCH_TO (LAUNCH_TO)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .grant      (slot_grant[s]),
      .x_in       (grant_x),
      .y_in       (grant_y),
      .dir_in     (grant_dir),
      .owner_in   (winner),
      .fb         (bul_fb[s]),
      .bul_state  (bul_state[s]),
      .bul_dir    (bul_dir[s*DIR_W +: DIR_W]),
      .bul_x_init (bul_x_init[s*POS_W +: POS_W]),
      .bul_y_init (bul_y_init[s*POS_W +: POS_W]),
      .owner      (slot_owner[s*OW +: OW]),
      .idle       (slot_idle[s]),
      .releasing  (slot_rel[s]),
      .busy_nx    (slot_busy_nx[s])
    );
  end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Directed self-checking bench for bullet_scheduler (LAUNCH_TO=16, COOLDOWN=8);
// cooldown timing is expected when BULLET_COOLDOWN_EN is defined.
module tb_bullet_scheduler;
  import bullet_sched_pkg::*;

  localparam int N_TANK = 4;
  localparam int N_BUL  = 4;
  localparam int OW     = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_TANK-1:0]       fire_req;
  logic [N_TANK*POS_W-1:0] fire_x, fire_y;
  logic [N_TANK*DIR_W-1:0] fire_dir;
  logic [N_TANK-1:0]       fire_ack, fire_busy;
  logic [N_BUL-1:0]        bul_state, bul_fb;
  logic [N_BUL*DIR_W-1:0]  bul_dir;
  logic [N_BUL*POS_W-1:0]  bul_x_init, bul_y_init;
  logic [N_BUL*OW-1:0]     slot_owner;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic [4:0] exp_x   [4] = '{5'd1, 5'd4, 5'd7, 5'd10};
  logic [4:0] exp_y   [4] = '{5'd31, 5'd30, 5'd29, 5'd28};
  logic [1:0] exp_dir [4] = '{DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};

  bullet_scheduler #(
    .N_TANK    (N_TANK),
    .N_BUL     (N_BUL),
    .LAUNCH_TO (16),
    .COOLDOWN  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fire_req   (fire_req),
    .fire_x     (fire_x),
    .fire_y     (fire_y),
    .fire_dir   (fire_dir),
    .fire_ack   (fire_ack),
    .fire_busy  (fire_busy),
    .bul_state  (bul_state),
    .bul_dir    (bul_dir),
    .bul_x_init (bul_x_init),
    .bul_y_init (bul_y_init),
    .bul_fb     (bul_fb),
    .slot_owner (slot_owner)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] fb);
    fire_req = req;
    bul_fb   = fb;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    fire_x   = '0;
    fire_y   = '0;
    fire_dir = '0;
    applyStimulus(4'b0000, 4'b0000);
    tick(3);
    checkOutput("rst_ack",   32'(fire_ack),   32'h0);
    checkOutput("rst_busy",  32'(fire_busy),  32'h0);
    checkOutput("rst_state", 32'(bul_state),  32'h0);
    checkOutput("rst_dir",   32'(bul_dir),    32'h0);
    checkOutput("rst_x",     32'(bul_x_init), 32'h0);
    checkOutput("rst_y",     32'(bul_y_init), 32'h0);
    checkOutput("rst_owner", 32'(slot_owner), 32'h0);

    // Single shot from tank 0 through LOAD, LAUNCH, FLY and RELEASE.
    rst      = 1'b0;
    fire_x   = 20'd5;
    fire_y   = 20'd10;
    fire_dir = {DIR_UP, DIR_UP, DIR_UP, DIR_UP};
    applyStimulus(4'b0001, 4'b0000);
    tick(1);
    checkOutput("t1_ack",   32'(fire_ack),        32'h1);
    checkOutput("t1_busy",  32'(fire_busy),       32'h1);
    checkOutput("t1_x",     32'(bul_x_init[4:0]), 32'd5);
    checkOutput("t1_y",     32'(bul_y_init[4:0]), 32'd10);
    checkOutput("t1_dir",   32'(bul_dir[1:0]),    32'(DIR_UP));
    checkOutput("t1_load",  32'(bul_state),       32'h0);
    applyStimulus(4'b0000, 4'b0000);
    tick(1);
    checkOutput("t1_rise",  32'(bul_state), 32'h1);
    checkOutput("t1_ack_1", 32'(fire_ack),  32'h0);
    tick(4);
    applyStimulus(4'b0000, 4'b0001);
    tick(20);
    applyStimulus(4'b0000, 4'b0000);
    tick(2);
    checkOutput("t1_hold",  32'(bul_state), 32'h1);
    tick(1);
    checkOutput("t1_fall",  32'(bul_state), 32'h0);
    checkOutput("t1_relb",  32'(fire_busy), 32'h1);
    tick(1);
    checkOutput("t1_idle",  32'(fire_busy), 32'h0);

    // All four tanks at once, from a freshly reset round-robin pointer.
    rst = 1'b1;
    tick(1);
    rst      = 1'b0;
    fire_x   = {exp_x[3], exp_x[2], exp_x[1], exp_x[0]};
    fire_y   = {exp_y[3], exp_y[2], exp_y[1], exp_y[0]};
    fire_dir = {DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP};
    applyStimulus(4'b1111, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      checkOutput("t2_ack",   32'(fire_ack),               32'(4'b0001 << k));
      checkOutput("t2_owner", 32'(slot_owner[k*2 +: 2]),   32'(k));
      checkOutput("t2_x",     32'(bul_x_init[k*5 +: 5]),   32'(exp_x[k]));
      checkOutput("t2_y",     32'(bul_y_init[k*5 +: 5]),   32'(exp_y[k]));
      checkOutput("t2_dir",   32'(bul_dir[k*2 +: 2]),      32'(exp_dir[k]));
      if (k == 0) bul_fb = 4'b1111;
    end
    checkOutput("t2_busy",   32'(fire_busy),  32'hF);
    checkOutput("t2_owners", 32'(slot_owner), 32'hE4);

    // Every slot busy: tank 1 waits until its own slot comes back to IDLE.
    applyStimulus(4'b0010, 4'b1111);
    tick(2);
    checkOutput("t3_fly",    32'(bul_state), 32'hF);
    checkOutput("t3_noack0", 32'(fire_ack),  32'h0);
    tick(1);
    checkOutput("t3_noack1", 32'(fire_ack),  32'h0);
    tick(1);
    applyStimulus(4'b0010, 4'b1101);
    tick(3);
    checkOutput("t3_fall",   32'(bul_state), 32'hD);
    checkOutput("t3_noack2", 32'(fire_ack),  32'h0);
    tick(1);
    checkOutput("t3_busy",   32'(fire_busy), 32'hD);
    checkOutput("t3_noack3", 32'(fire_ack),  32'h0);
`ifdef BULLET_COOLDOWN_EN
    tick(8);
    checkOutput("t3_cool",   32'(fire_ack),  32'h0);
`endif
    tick(1);
    checkOutput("t3_ack",    32'(fire_ack),           32'h2);
    checkOutput("t3_slot",   32'(slot_owner[3:2]),    32'd1);
    checkOutput("t3_busy2",  32'(fire_busy),          32'hF);
    applyStimulus(4'b0000, 4'b1101);

    // Slot 1 relaunches with no feedback and must abort after 16 LAUNCH cycles.
    tick(1);
    checkOutput("t4_rise",  32'(bul_state[1]), 32'h1);
    tick(15);
    checkOutput("t4_last",  32'(bul_state[1]), 32'h1);
    tick(1);
    checkOutput("t4_abort", 32'(bul_state[1]), 32'h0);
    checkOutput("t4_relb",  32'(fire_busy[1]), 32'h1);
    tick(1);
    checkOutput("t4_idle",  32'(fire_busy),    32'hD);

    // One-cycle reset while three slots are in FLY.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkOutput("t5_state", 32'(bul_state), 32'h0);
    checkOutput("t5_busy",  32'(fire_busy), 32'h0);
    checkOutput("t5_ack",   32'(fire_ack),  32'h0);
    applyStimulus(4'b1010, 4'b0000);
    tick(1);
    checkOutput("t5_rrptr", 32'(fire_ack),  32'h2);

    // Tank 2 autofire: re-granted once its slot is IDLE (and cooled down).
    applyStimulus(4'b0100, 4'b0000);
    tick(1);
    checkOutput("t6_ack",   32'(fire_ack),        32'h4);
    checkOutput("t6_slot",  32'(slot_owner[3:2]), 32'd2);
    checkOutput("t6_busy",  32'(fire_busy),       32'h6);
    applyStimulus(4'b0100, 4'b0010);
    tick(6);
    checkOutput("t6_fly",   32'(bul_state), 32'h3);
    applyStimulus(4'b0100, 4'b0000);
    tick(3);
    checkOutput("t6_fall",  32'(bul_state), 32'h1);
    tick(1);
    checkOutput("t6_idle",  32'(fire_busy[2]), 32'h0);
    checkOutput("t6_noack", 32'(fire_ack),     32'h0);
`ifdef BULLET_COOLDOWN_EN
    tick(8);
    checkOutput("t6_cool",  32'(fire_ack),     32'h0);
`endif
    tick(1);
    checkOutput("t6_regrant", 32'(fire_ack), 32'h4);
    applyStimulus(4'b0000, 4'b0000);

    if (fail_cnt != 0) $display("[TB] %0d comparisons reported errors", fail_cnt);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/bullet_scheduler.md
# bullet_scheduler

Shares a pool of `N_BUL` bullet engines among `N_TANK` tanks. It grants fire requests round-robin and loads each granted shot's start position and direction into a free engine. It then sequences the engine's `bul_state` launch level and tracks the engine's `bul_state_feedback` until the bullet reaches the arena boundary. It sits between the tank controllers and the bank of bullet engines, in the `clk` domain.

## Interface
- `N_TANK`, 4: number of requesting tanks; `OW = $clog2(N_TANK)`.
- `N_BUL`, 4: number of bullet engines (slots).
- `LAUNCH_TO`, 8_000_000: cycles to wait in LAUNCH for feedback to rise before aborting; counter is 24 bits.
- `COOLDOWN`, 6_250_000: per-tank re-arm delay in cycles; used only with `BULLET_COOLDOWN_EN`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `fire_req` in N_TANK: level fire request per tank.
- `fire_x` / `fire_y` in N_TANK*5: tank grid position, packed with tank i at [5i+4:5i].
- `fire_dir` in N_TANK*2: packed direction; 00 up, 01 down, 10 left, 11 right.
- `fire_ack` out N_TANK: one-cycle grant pulse.
- `fire_busy` out N_TANK: tank owns a slot not in IDLE.
- `bul_state` out N_BUL: launch level to each engine.
- `bul_dir` out N_BUL*2: direction to each engine.
- `bul_x_init` / `bul_y_init` out N_BUL*5: start position to each engine.
- `bul_fb` in N_BUL: `bul_state_feedback` from each engine; asynchronous to `clk` (8 Hz domain).
- `slot_owner` out N_BUL*OW: tank index that owns each slot.

## Operation
- `bul_fb` passes through a 2-FF synchronizer per slot. FSM decisions use the synchronized value `fb_s`.
- Each slot runs its own FSM: IDLE -> LOAD -> LAUNCH -> FLY -> RELEASE -> IDLE.
  - IDLE: `bul_state`=0. On grant, the slot captures x, y, dir and owner, then goes to LOAD.
  - LOAD (1 cycle): `bul_dir`/`bul_x_init`/`bul_y_init` are driven stable. `bul_state` stays 0, so the engine samples valid data on the rising edge.
  - LAUNCH: `bul_state`=1. On `fb_s`=1 go to FLY. If the timeout counter reaches `LAUNCH_TO`-1 first, go to RELEASE (abort).
  - FLY: `bul_state`=1. On `fb_s`=0 (boundary reached) go to RELEASE.
  - RELEASE (1 cycle): `bul_state`=0, then IDLE.
- A tank is eligible when all of the following hold:
  - `fire_req` is 1.
  - The tank does not own a non-IDLE slot (one bullet per tank).
  - With cooldown enabled, its cooldown counter is 0.
- Arbitration:
  - At most one grant per cycle.
  - The winner is the first eligible tank at or after `rr_ptr`, searching cyclically.
  - The slot used is the lowest-index IDLE slot.
  - A grant requires at least one IDLE slot. With no IDLE slot there is no grant and `rr_ptr` is unchanged.
  - After a grant, `rr_ptr` = winner+1 mod `N_TANK`.
- `fire_req` held high means autofire: the tank is re-granted as soon as it is eligible again.
- A slot entering IDLE in cycle T is grantable in cycle T+1, not in T.
- Reset values:
  - all slots IDLE;
  - `bul_state`, `fire_ack`, `fire_busy` = 0;
  - `bul_dir`, `bul_x_init`, `bul_y_init`, `slot_owner` = 0;
  - `rr_ptr`, cooldown counters, timeout counters and synchronizers = 0.
- Reset mid-flight forces `bul_state` low in the same cycle the reset is sampled. The engines then park their bullets on their next 8 Hz edge.

## Timing
- Grant cycle T: `fire_ack` pulses and `fire_busy` rises, both registered and visible at T+1.
- `bul_dir`/`bul_x_init`/`bul_y_init` are valid from T+1. `bul_state` rises at T+2.
- Feedback latency is 2 cycles of synchronizer plus 1 FSM cycle. `bul_state` falls 3 cycles after `bul_fb` falls. This is well inside one 8 Hz period, so the engine never re-samples.
- All outputs are registered. There is no combinational path from `fire_req` to any output.

## Configuration
- `BULLET_COOLDOWN_EN` defined:
  - Each tank has a counter loaded with `COOLDOWN` when its slot leaves RELEASE.
  - The counter decrements to 0; the tank is ineligible while it is nonzero.
  - Reset clears the counter.
- `BULLET_COOLDOWN_EN` undefined: there are no counters, and a tank is eligible in the cycle after its slot returns to IDLE.

## Structure
- Package `bullet_sched_pkg` holds:
  - the slot state enum (IDLE, LOAD, LAUNCH, FLY, RELEASE);
  - `POS_W`=5 and `DIR_W`=2;
  - the direction constants `DIR_UP`=00, `DIR_DOWN`=01, `DIR_LEFT`=10, `DIR_RIGHT`=11.
- Sub-module `bullet_slot_fsm` contains one slot: synchronizer, FSM, timeout counter and captured registers. It is instantiated `N_BUL` times.
- The arbiter, `rr_ptr` and cooldown counters live in the top level.

## Test plan
- Test parameters: `LAUNCH_TO`=16, `COOLDOWN`=8.
- Tank 0 requests with x=5, y=10, dir=00; `bul_fb` pulses high 6 cycles later, then low 20 cycles later. Required: `fire_ack[0]` at T+1, slot 0 loads 5/10/00 at T+1, `bul_state[0]` rises at T+2 and falls 3 cycles after `bul_fb` falls.
- All 4 tanks request simultaneously with 4 free slots. Required: grants to tanks 0,1,2,3 in consecutive cycles, using slots 0,1,2,3.
- All slots busy and tank 1 requests. Required: no ack. The first slot to reach IDLE is granted to tank 1 the following cycle.
- Slot launched and `bul_fb` never rises. Required: abort after 16 LAUNCH cycles, `bul_state` low, slot back in IDLE and the owner's `fire_busy` cleared.
- Tank 2 holds `fire_req` with `BULLET_COOLDOWN_EN` defined. Required: re-grant exactly 8 cycles after RELEASE. With the macro undefined: re-grant on the cycle after IDLE.
- Assert `rst` for 1 cycle during FLY. Required: all `bul_state`=0 and all `fire_busy`=0 on the next cycle, and `rr_ptr`=0.
